// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and helpers for the N-to-1 stream mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant, searching upward from last+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    input  logic             enable,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int w_pos;

    // last is always a legal channel index, so one subtraction wraps it.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_pos     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            w_pos = int'(last) + k;
            if (w_pos >= N_CH) begin
                w_pos = w_pos - N_CH;
            end
            if (enable && !gnt_valid && req[w_pos]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_stream_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_nto1
//  Description : N-to-1 valid/ready stream mux, fixed or round-robin select,
//                single registered output stage with full throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_stream_nto1
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    localparam int SEL_W = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PAD_W = 1 << SEL_W;

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_last;

    logic [PAD_W-1:0] w_valid_pad;
    logic             w_fix_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_free;
    logic             w_take;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .last      (r_last),
        .enable    (mode == MODE_RR),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    // Padding makes an out-of-range sel read as "not valid".
    assign w_valid_pad = PAD_W'(in_valid);
    assign w_fix_valid = w_valid_pad[sel];

    assign w_gnt_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
    assign w_gnt_idx   = (mode == MODE_RR) ? w_rr_idx
                       : (w_fix_valid ? sel : '0);

    assign w_free     = !r_out_valid || out_ready;
    assign w_take     = rst_n && w_gnt_valid && w_free;
    assign in_ready   = w_take ? (N_CH'(1) << w_gnt_idx) : '0;
    assign w_sel_data = in_data[w_gnt_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_last      <= SEL_W'(N_CH - 1);
        end else if (w_take) begin
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_last      <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
